// File: rtl/vec_elem_sequencer_pkg.sv
// Shared encodings and default sizing for the vector element sequencer.
// Operand-B source codes and FSM state codes live here so every file agrees on them.
package vec_elem_sequencer_pkg;

    localparam int DEF_VLMAX = 32;
    localparam int DEF_ELEN  = 64;

    localparam logic [1:0] OPSRC_VV  = 2'd0;
    localparam logic [1:0] OPSRC_VX  = 2'd1;
    localparam logic [1:0] OPSRC_VI  = 2'd2;
    localparam logic [1:0] OPSRC_RSV = 2'd3;

    localparam logic [1:0] SEQ_IDLE  = 2'd0;
    localparam logic [1:0] SEQ_ISSUE = 2'd1;
    localparam logic [1:0] SEQ_DONE  = 2'd2;

endpackage

// File: rtl/vec_elem_sequencer_if.sv
// Decode-side instruction handshake plus ALU-side element handshake of the sequencer.
// The slave modport is the sequencer's view; master is the decode/ALU environment.
interface vec_elem_sequencer_if
    import vec_elem_sequencer_pkg::*;
#(
    parameter int VLMAX = DEF_VLMAX,
    parameter int ELEN  = DEF_ELEN
);
    localparam int IDX_W = $clog2(VLMAX);
    localparam int VL_W  = $clog2(VLMAX) + 1;

    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        op_src;
    logic [4:0]        vs1;
    logic [4:0]        vs2;
    logic [4:0]        vd;
    logic [VL_W-1:0]   vl;
    logic [4:0]        simm5;
    logic [31:0]       scalar_in;
    logic              kill;

    logic              elem_valid;
    logic              elem_ready;
    logic [IDX_W-1:0]  elem_idx;
    logic [4:0]        vs1_reg;
    logic [4:0]        vs2_reg;
    logic [4:0]        vd_reg;
    logic              opb_sel;
    logic [ELEN-1:0]   opb_scalar;
    logic              elem_last;
    logic              done;
    logic              illegal;

    modport slave (
        input  instr_valid, op_src, vs1, vs2, vd, vl, simm5, scalar_in, kill, elem_ready,
        output instr_ready, elem_valid, elem_idx, vs1_reg, vs2_reg, vd_reg,
               opb_sel, opb_scalar, elem_last, done, illegal
    );

    modport master (
        output instr_valid, op_src, vs1, vs2, vd, vl, simm5, scalar_in, kill, elem_ready,
        input  instr_ready, elem_valid, elem_idx, vs1_reg, vs2_reg, vd_reg,
               opb_sel, opb_scalar, elem_last, done, illegal
    );

endinterface

// File: rtl/vec_elem_sequencer_sign_ext_64.sv
// Broadcast operand generator: sign-extends the VX scalar or the VI immediate to 64 bits.
module sign_ext_64
    import vec_elem_sequencer_pkg::*;
(
    input  logic [1:0]  op_src,
    input  logic [4:0]  simm5,
    input  logic [31:0] scalar_in,
    output logic [63:0] value
);

    always_comb begin
        // NOTE: default first so every path assigns value and no latch is inferred.
        value = '0;
        case (op_src)
            OPSRC_VX: value = {{32{scalar_in[31]}}, scalar_in};
            OPSRC_VI: value = {{59{simm5[4]}}, simm5};
            default:  value = '0;
        endcase
    end

endmodule

// File: rtl/vec_elem_sequencer.sv
// Per-instruction element sequencer: accepts one decoded OPIVV/OPIVX/OPIVI instruction
// and walks the element index 0..vl-1, one ALU handshake per element.
module vec_elem_sequencer
    import vec_elem_sequencer_pkg::*;
#(
    parameter int VLMAX = DEF_VLMAX,
    parameter int ELEN  = DEF_ELEN
)(
    input  logic clk,
    input  logic rst,
    vec_elem_sequencer_if.slave seq
);

    localparam int IDX_W = $clog2(VLMAX);
    localparam int VL_W  = $clog2(VLMAX) + 1;
    localparam logic [VL_W-1:0] VLMAX_V = VL_W'(VLMAX);

    logic [1:0]       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [VL_W-1:0]  vl_eff_q;
    logic [4:0]       vs1_q, vs2_q, vd_q;
    logic             opb_sel_q;
    logic [ELEN-1:0]  opb_q;
    logic             done_q;
    logic             illegal_q;

    logic [ELEN-1:0]  bcast;
    logic [VL_W-1:0]  vl_clamp;
    logic             last;

    sign_ext_64 u_sign_ext (
        .op_src    (seq.op_src),
        .simm5     (seq.simm5),
        .scalar_in (seq.scalar_in),
        .value     (bcast)
    );

    assign vl_clamp = (seq.vl > VLMAX_V) ? VLMAX_V : seq.vl;

    // Decoded from registers only, so no input reaches these outputs combinationally.
    assign last = (state_q == SEQ_ISSUE) && ({1'b0, idx_q} == (vl_eff_q - VL_W'(1)));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q   <= SEQ_IDLE;
            idx_q     <= '0;
            vl_eff_q  <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            opb_sel_q <= 1'b0;
            opb_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (seq.kill) begin
                state_q <= SEQ_IDLE;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    SEQ_IDLE: begin
                        if (seq.instr_valid) begin
                            vs1_q     <= seq.vs1;
                            vs2_q     <= seq.vs2;
                            vd_q      <= seq.vd;
                            vl_eff_q  <= vl_clamp;
                            opb_q     <= bcast;
                            opb_sel_q <= (seq.op_src != OPSRC_VV);
                            idx_q     <= '0;
                            // Reserved source and empty vectors skip straight to completion.
                            if (seq.op_src == OPSRC_RSV) begin
                                state_q   <= SEQ_DONE;
                                done_q    <= 1'b1;
                                illegal_q <= 1'b1;
                            end else if (vl_clamp == '0) begin
                                state_q <= SEQ_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= SEQ_ISSUE;
                            end
                        end
                    end
                    SEQ_ISSUE: begin
                        if (seq.elem_ready) begin
                            if (last) begin
                                state_q <= SEQ_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                    SEQ_DONE: state_q <= SEQ_IDLE;
                    default:  state_q <= SEQ_IDLE;
                endcase
            end
        end
    end

    assign seq.instr_ready = (state_q == SEQ_IDLE);
    assign seq.elem_valid  = (state_q == SEQ_ISSUE);
    assign seq.elem_last   = last;
    assign seq.elem_idx    = idx_q;
    assign seq.vs1_reg     = vs1_q;
    assign seq.vs2_reg     = vs2_q;
    assign seq.vd_reg      = vd_q;
    assign seq.opb_sel     = opb_sel_q;
    assign seq.opb_scalar  = opb_q;
    assign seq.done        = done_q;
    assign seq.illegal     = illegal_q;

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Scoreboard bench for vec_elem_sequencer: directed instructions push expected element
// handshakes and completions; a negedge monitor pops and compares them.
module tb_vec_elem_sequencer;
    import vec_elem_sequencer_pkg::*;

    typedef struct packed {
        logic [4:0]  idx;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  vd;
        logic        sel;
        logic [63:0] opb;
        logic        last;
    } elem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_elem_sequencer_if bus ();

    vec_elem_sequencer dut (
        .clk (clk),
        .rst (rst),
        .seq (bus.slave)
    );

    int    errors = 0;
    int    checks = 0;
    elem_t sb_q[$];
    logic  done_q[$];
    logic  ready_q[$];

    task automatic check(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives elem_ready per valid cycle from ready_q, defaulting to 1.
    initial begin
        bus.elem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.elem_valid && ready_q.size() > 0) bus.elem_ready = ready_q.pop_front();
            else bus.elem_ready = 1'b1;
        end
    end

    // Monitor: element handshakes, completion pulses and stall stability.
    initial begin
        bit         stalled;
        logic [4:0] stall_idx;
        elem_t      exp_e;
        elem_t      act_e;
        logic       exp_ill;
        stalled   = 1'b0;
        stall_idx = '0;
        forever begin
            @(negedge clk);
            if (stalled)
                check("stall_hold", bus.elem_valid && bus.elem_idx == stall_idx,
                      {bus.elem_valid, bus.elem_idx}, {1'b1, stall_idx});
            if (bus.elem_valid && bus.elem_ready) begin
                act_e = '{idx: bus.elem_idx, vs1: bus.vs1_reg, vs2: bus.vs2_reg, vd: bus.vd_reg,
                          sel: bus.opb_sel, opb: bus.opb_scalar, last: bus.elem_last};
                if (sb_q.size() == 0) begin
                    check("unexpected_elem", 1'b0, act_e, 0);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("elem", act_e == exp_e, act_e, exp_e);
                end
            end
            stalled   = bus.elem_valid && !bus.elem_ready;
            stall_idx = bus.elem_idx;
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1'b0, 1, 0);
                end else begin
                    exp_ill = done_q.pop_front();
                    check("done_illegal", bus.illegal == exp_ill, bus.illegal, exp_ill);
                end
            end else if (bus.illegal) begin
                check("illegal_without_done", 1'b0, 1, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset(input string tag);
        check({tag, "_ready_valid"}, bus.instr_ready && !bus.elem_valid,
              {bus.instr_ready, bus.elem_valid}, 2'b10);
        check({tag, "_flags"}, {bus.done, bus.illegal, bus.elem_last, bus.opb_sel} == 4'b0,
              {bus.done, bus.illegal, bus.elem_last, bus.opb_sel}, 0);
        check({tag, "_idx"}, bus.elem_idx == 5'd0, bus.elem_idx, 0);
        check({tag, "_regs"}, {bus.vs1_reg, bus.vs2_reg, bus.vd_reg} == 15'd0,
              {bus.vs1_reg, bus.vs2_reg, bus.vd_reg}, 0);
        check({tag, "_opb"}, bus.opb_scalar == 64'd0, bus.opb_scalar, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 of the acceptance cycle.
    task automatic start_instr(input logic [1:0] src, input logic [5:0] vl_i, input logic [4:0] simm,
                               input logic [31:0] scal, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic exp_sel, input logic [63:0] exp_opb,
                               input int n_elem, input int n_push, input bit exp_done, input bit exp_ill);
        int w;
        w = 0;
        while (!bus.instr_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("instr_ready_wait", bus.instr_ready, bus.instr_ready, 1);
        for (int i = 0; i < n_push; i++)
            sb_q.push_back('{idx: 5'(i), vs1: r1, vs2: r2, vd: rd, sel: exp_sel, opb: exp_opb,
                             last: (i == n_elem - 1)});
        if (exp_done) done_q.push_back(exp_ill);
        bus.op_src      = src;
        bus.vl          = vl_i;
        bus.simm5       = simm;
        bus.scalar_in   = scal;
        bus.vs1         = r1;
        bus.vs2         = r2;
        bus.vd          = rd;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    // Counts cycles from acceptance to done, then checks the return to IDLE.
    task automatic finish_instr(input int exp_lat, input string tag);
        int k;
        bit seen;
        k    = 0;
        seen = 1'b0;
        while (k < 300) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            k++;
        end
        check({tag, "_done_seen"}, seen, seen, 1);
        if (seen) begin
            check({tag, "_latency"}, k == exp_lat, k, exp_lat);
            check({tag, "_busy_in_done"}, !bus.instr_ready && !bus.elem_valid,
                  {bus.instr_ready, bus.elem_valid}, 0);
        end
        @(negedge clk);
        check({tag, "_ready_after_done"}, bus.instr_ready && !bus.done,
              {bus.instr_ready, bus.done}, 2'b10);
        check({tag, "_sb_empty"}, sb_q.size() == 0 && done_q.size() == 0,
              {sb_q.size(), done_q.size()}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [4:0] target, input string tag);
        int w;
        w = 0;
        while (bus.elem_idx != target && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check({tag, "_reach_idx"}, bus.elem_valid && bus.elem_idx == target,
              {bus.elem_valid, bus.elem_idx}, {1'b1, target});
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.op_src      = '0;
        bus.vs1         = '0;
        bus.vs2         = '0;
        bus.vd          = '0;
        bus.vl          = '0;
        bus.simm5       = '0;
        bus.scalar_in   = '0;
        bus.kill        = 1'b0;
        rst             = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // VV, vl=4, ready held high.
        start_instr(OPSRC_VV, 6'd4, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 64'h0, 4, 4, 1'b1, 1'b0);
        finish_instr(4, "vv4");

        // Broadcast forms.
        start_instr(OPSRC_VI, 6'd2, 5'b10110, 32'h0, 5'd4, 5'd5, 5'd6, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFF6, 2, 2, 1'b1, 1'b0);
        finish_instr(2, "vi_neg");
        start_instr(OPSRC_VX, 6'd1, 5'd0, 32'h8000_0001, 5'd7, 5'd8, 5'd9, 1'b1,
                    64'hFFFF_FFFF_8000_0001, 1, 1, 1'b1, 1'b0);
        finish_instr(1, "vx_neg");
        start_instr(OPSRC_VX, 6'd3, 5'd0, 32'h1234_5678, 5'd10, 5'd11, 5'd12, 1'b1,
                    64'h0000_0000_1234_5678, 3, 3, 1'b1, 1'b0);
        finish_instr(3, "vx_pos");

        // Stall: ready pattern 1,0,0,1,1 over the valid cycles.
        ready_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        start_instr(OPSRC_VV, 6'd3, 5'd0, 32'h0, 5'd13, 5'd14, 5'd15, 1'b0, 64'h0, 3, 3, 1'b1, 1'b0);
        finish_instr(5, "stall");

        // Boundaries: empty vector, clamped vl, reserved source.
        start_instr(OPSRC_VV, 6'd0, 5'd0, 32'h0, 5'd16, 5'd17, 5'd18, 1'b0, 64'h0, 0, 0, 1'b1, 1'b0);
        finish_instr(0, "vl0");
        start_instr(OPSRC_VI, 6'd40, 5'b00011, 32'h0, 5'd19, 5'd20, 5'd21, 1'b1,
                    64'h0000_0000_0000_0003, 32, 32, 1'b1, 1'b0);
        finish_instr(32, "vl40");
        start_instr(OPSRC_RSV, 6'd4, 5'b11111, 32'h0, 5'd22, 5'd23, 5'd24, 1'b1, 64'h0, 0, 0, 1'b1, 1'b1);
        finish_instr(0, "rsv");

        // kill together with instr_valid in IDLE drops the instruction.
        bus.op_src      = OPSRC_VV;
        bus.vl          = 6'd4;
        bus.instr_valid = 1'b1;
        bus.kill        = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.kill        = 1'b0;
        @(negedge clk);
        check("kill_idle_dropped", bus.instr_ready && !bus.elem_valid,
              {bus.instr_ready, bus.elem_valid}, 2'b10);
        @(posedge clk);
        #1;

        // kill at idx 2 of vl=8; the idx-2 handshake is seen in the kill cycle.
        start_instr(OPSRC_VV, 6'd8, 5'd0, 32'h0, 5'd25, 5'd26, 5'd27, 1'b0, 64'h0, 8, 3, 1'b0, 1'b0);
        wait_idx(5'd2, "kill");
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        check("kill_outputs", {bus.elem_valid, bus.done, bus.instr_ready, bus.elem_idx} == {3'b001, 5'd0},
              {bus.elem_valid, bus.done, bus.instr_ready, bus.elem_idx}, {3'b001, 5'd0});
        check("kill_sb_empty", sb_q.size() == 0, sb_q.size(), 0);
        @(posedge clk);
        #1;
        start_instr(OPSRC_VV, 6'd2, 5'd0, 32'h0, 5'd28, 5'd29, 5'd30, 1'b0, 64'h0, 2, 2, 1'b1, 1'b0);
        finish_instr(2, "after_kill");

        // rst at idx 5 mid-ISSUE.
        start_instr(OPSRC_VX, 6'd16, 5'd0, 32'hDEAD_BEEF, 5'd31, 5'd1, 5'd2, 1'b1,
                    64'hFFFF_FFFF_DEAD_BEEF, 16, 6, 1'b0, 1'b0);
        wait_idx(5'd5, "rst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        check("rst_sb_empty", sb_q.size() == 0, sb_q.size(), 0);
        @(posedge clk);
        #1;
        start_instr(OPSRC_VV, 6'd1, 5'd0, 32'h0, 5'd3, 5'd4, 5'd5, 1'b0, 64'h0, 1, 1, 1'b1, 1'b0);
        finish_instr(1, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_elem_sequencer.md
Name: vec_elem_sequencer

Overview:
- Per-instruction element sequencer for the vector integer unit. Accepts one decoded OPIVV/OPIVX/OPIVI instruction, then steps the element index from 0 to vl-1, one element per ALU handshake.
- Presents operand B as either the vs1 element or the sign-extended scalar/immediate broadcast (sign_ext_64).
- Sits between the vector decode stage and the vector ALU / VRF read ports. It pulses done when the last element retires.

Parameters:
- VLMAX, 32, maximum element count per instruction (power of two).
- ELEN, 64, element/operand width in bits.
- IDX_W, $clog2(VLMAX), element index width.
- VL_W, $clog2(VLMAX)+1, width of the vl field.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  decoded instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- op_src  in  2  operand-B source: 0=VV, 1=VX, 2=VI, 3=reserved.
- vs1  in  5  vs1 register number.
- vs2  in  5  vs2 register number.
- vd  in  5  vd register number.
- vl  in  VL_W  active vector length.
- simm5  in  5  immediate (VI form).
- scalar_in  in  32  rs1 value (VX form).
- kill  in  1  abort current instruction (trap/flush).
- elem_valid  out  1  element operands valid to ALU.
- elem_ready  in  1  ALU accepts element.
- elem_idx  out  IDX_W  current element index.
- vs1_reg, vs2_reg, vd_reg  out  5 each  latched register numbers.
- opb_sel  out  1  0 = use vs1 element, 1 = use opb_scalar.
- opb_scalar  out  ELEN  sign-extended broadcast operand.
- elem_last  out  1  current element is index vl-1.
- done  out  1  one-cycle pulse, instruction complete.
- illegal  out  1  one-cycle pulse together with done for op_src=3.

Behaviour:
- Reset (rst=1 at posedge) state and outputs:
  - state=IDLE, instr_ready=1.
  - elem_valid, done, illegal, elem_last, opb_sel = 0.
  - elem_idx, all latched registers, opb_scalar = 0.
  - rst has priority over kill and every handshake.
- FSM states are IDLE, ISSUE and DONE.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch op_src, vs1/vs2/vd, and vl_eff = min(vl, VLMAX).
  - Latch opb_scalar from sign_ext_64: VX uses scalar_in_64, VI uses simm64, VV gives 0.
  - Latch opb_sel = (op_src != VV). Set elem_idx=0.
  - Next state: op_src=3 → DONE with illegal; vl_eff=0 → DONE; otherwise → ISSUE.
- ISSUE:
  - instr_ready=0, elem_valid=1.
  - elem_last = (elem_idx == vl_eff-1).
  - On elem_valid & elem_ready: if elem_last → DONE, else elem_idx+1.
  - Without elem_ready, all outputs hold stable (elem_valid must not drop).
- DONE:
  - done=1 (and illegal=1 if flagged) for exactly one cycle, then → IDLE.
  - instr_ready=0 in DONE. The next instruction is accepted at the earliest on the cycle after done.
- Latency:
  - First elem_valid appears 1 cycle after acceptance.
  - With elem_ready held high, N elements take N cycles; done comes the cycle after the last handshake.
  - Minimum instruction occupancy is therefore N+2 cycles.
- kill, in any state (no rst):
  - Next state is IDLE, elem_valid=0, no done pulse, elem_idx=0.
  - If kill coincides with instr_valid in IDLE, the instruction is dropped.
- vl > VLMAX is clamped silently. The index never wraps past vl_eff-1.
- Sign extension is fixed:
  - simm5 bit 4 is replicated into bits 63:5.
  - scalar_in bit 31 is replicated into bits 63:32.
- Outputs are registered except instr_ready, elem_valid and elem_last, which are decoded from state and registers only (no input→output combinational path).

Decomposition:
- Shared package/header (constants.vh): op_src encodings OPSRC_VV/VX/VI/RSV, FSM state encodings SEQ_IDLE/ISSUE/DONE, default VLMAX/ELEN.
- Instantiate the existing sign_ext_64 module once for broadcast generation. No other sub-module.

Test Plan:
- VV, vl=4, elem_ready=1 → elem_idx 0,1,2,3 on consecutive cycles, opb_sel=0, elem_last only at idx 3, done one cycle later, instr_ready back on the next cycle.
- VI, simm5=5'b10110, vl=2 → opb_scalar=64'hFFFF_FFFF_FFFF_FFF6, opb_sel=1; VX, scalar_in=32'h8000_0001 → opb_scalar=64'hFFFF_FFFF_8000_0001.
- VV, vl=3, elem_ready toggled 1,0,0,1,1 → elem_idx holds at 1 through the stall, elem_valid never drops, exactly 3 handshakes, then done.
- vl=0 → no elem_valid, done 1 cycle after acceptance; vl=40 → exactly 32 elements, last idx=31; op_src=3 → done and illegal pulse together, no elements.
- kill asserted at idx=2 of vl=8 → elem_valid=0 the next cycle, no done, instr_ready=1, and a following instruction restarts at idx 0.
- rst asserted mid-ISSUE at idx=5 → the next cycle shows all outputs at reset values, state IDLE.
